// File: rtl/kp_kernel_window.sv
// kp_kernel_window: KSIZE x KSIZE sliding-window generator for raster pixel
// streams. KSIZE-1 line buffers feed a KSIZE x KSIZE tap register; one full
// window is emitted per accepted pixel inside the valid region, with
// ready/valid backpressure, frame/line markers and start-of-frame resync.
module kp_kernel_window #(
  parameter int LINE_LENGTH = 640,
  parameter int LINE_COUNT  = 480,
  parameter int DATA_WIDTH  = 16,
  parameter int KSIZE       = 3
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [DATA_WIDTH-1:0]               i_data,
  input  logic                                i_valid,
  input  logic                                i_sof,
  output logic                                o_ready,
  output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   o_window,
  output logic                                o_valid,
  output logic                                o_sof,
  output logic                                o_eol,
  output logic                                o_eof,
  input  logic                                i_ready,
  output logic                                o_sof_err
);

  localparam int XW    = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int YW    = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;
  localparam int NTAPS = KSIZE * KSIZE;

  localparam logic [XW-1:0] X_LAST  = XW'(LINE_LENGTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(LINE_COUNT - 1);
  localparam logic [XW-1:0] X_FIRST = XW'(KSIZE - 1);
  localparam logic [YW-1:0] Y_FIRST = YW'(KSIZE - 1);

  logic [XW-1:0]         x_q, x_eff, x_next;
  logic [YW-1:0]         y_q, y_eff, y_next;
  logic                  accept;
  logic                  at_origin;
  logic                  in_region;
  logic [DATA_WIDTH-1:0] lb    [KSIZE-1][LINE_LENGTH];
  logic [DATA_WIDTH-1:0] lb_rd [KSIZE-1];
  logic [DATA_WIDTH-1:0] taps  [NTAPS];

  // Combinational ready: a held window blocks input, no skid buffer.
  assign o_ready = ~i_rst & (~o_valid | i_ready);
  assign accept  = i_valid & o_ready;

  // An accepted i_sof forces the pixel to (0,0) regardless of the counters.
  assign at_origin = (x_q == '0) && (y_q == '0);
  assign x_eff     = i_sof ? '0 : x_q;
  assign y_eff     = i_sof ? '0 : y_q;
  assign in_region = (x_eff >= X_FIRST) && (y_eff >= Y_FIRST);

  // Raster position that follows the pixel being accepted.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    x_next = x_eff + 1'b1;
    y_next = y_eff;
    if (x_eff == X_LAST) begin
      x_next = '0;
      y_next = (y_eff == Y_LAST) ? '0 : y_eff + 1'b1;
    end
  end

  // Read every line buffer at the current column before this cycle's write.
  always_comb begin
    for (int j = 0; j < KSIZE - 1; j++) begin
      lb_rd[j] = lb[j][x_eff];
    end
  end

  // Line buffers cascade one line deeper at the current column on accept.
  // NOTE: the line buffers are plain storage with no reset; stale lines are never emitted because output is gated on y.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb[0][x_eff] <= i_data;
      for (int j = 1; j < KSIZE - 1; j++) begin
        lb[j][x_eff] <= lb_rd[j-1];
      end
    end
  end

  // Counters, tap shift register and registered window/marker outputs.
  // NOTE: all sequential state uses non-blocking assignments so the tap shift reads pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q       <= '0;
      y_q       <= '0;
      o_valid   <= 1'b0;
      o_sof     <= 1'b0;
      o_eol     <= 1'b0;
      o_eof     <= 1'b0;
      o_sof_err <= 1'b0;
      for (int t = 0; t < NTAPS; t++) begin
        taps[t] <= '0;
      end
    end else begin
      o_sof_err <= accept & i_sof & ~at_origin;
      if (accept) begin
        x_q <= x_next;
        y_q <= y_next;
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE - 1; c++) begin
            taps[r*KSIZE+c] <= taps[r*KSIZE+c+1];
          end
        end
        // Newest column, oldest line at the top, incoming pixel at the bottom.
        for (int r = 0; r < KSIZE - 1; r++) begin
          taps[r*KSIZE+KSIZE-1] <= lb_rd[KSIZE-2-r];
        end
        taps[NTAPS-1] <= i_data;
        o_valid <= in_region;
        o_sof   <= in_region && (x_eff == X_FIRST) && (y_eff == Y_FIRST);
        o_eol   <= in_region && (x_eff == X_LAST);
        o_eof   <= in_region && (x_eff == X_LAST) && (y_eff == Y_LAST);
      end else if (i_ready) begin
        o_valid <= 1'b0;
        o_sof   <= 1'b0;
        o_eol   <= 1'b0;
        o_eof   <= 1'b0;
      end
    end
  end

  // Flatten the taps: tap (r,c) sits at slot r*KSIZE+c.
  for (genvar t = 0; t < NTAPS; t++) begin : g_window
    assign o_window[t*DATA_WIDTH +: DATA_WIDTH] = taps[t];
  end

endmodule

// File: tb/tb_kp_kernel_window.sv
// tb_kp_kernel_window: directed bench for kp_kernel_window. Instance a uses
// KSIZE=3 on an 8x6 frame, instance b uses KSIZE=5 on a 16x8 frame. Pixels
// are (y<<4)|x; expected windows come from that formula.
module tb_kp_kernel_window;

  localparam int DW  = 16;
  localparam int K   = 3;
  localparam int LL  = 8;
  localparam int LC  = 6;
  localparam int WA  = K * K * DW;
  localparam int KB  = 5;
  localparam int LLB = 16;
  localparam int LCB = 8;
  localparam int WB  = KB * KB * DW;

  typedef struct { logic [DW-1:0] d; logic sof; logic mark; } px_t;
  typedef struct { logic [WA-1:0] w; logic sof; logic eol; logic eof; } win_t;
  typedef struct { int x; int y; } pos_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] a_data;
  logic          a_valid, a_sof, a_oready, a_ovalid, a_osof, a_oeol, a_oeof, a_iready, a_sof_err;
  logic [WA-1:0] a_window;
  logic [DW-1:0] b_data;
  logic          b_valid, b_sof, b_oready, b_ovalid, b_osof, b_oeol, b_oeof, b_iready, b_sof_err;
  logic [WB-1:0] b_window;

  kp_kernel_window #(.LINE_LENGTH(LL), .LINE_COUNT(LC), .DATA_WIDTH(DW), .KSIZE(K)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_data(a_data), .i_valid(a_valid), .i_sof(a_sof),
    .o_ready(a_oready), .o_window(a_window), .o_valid(a_ovalid), .o_sof(a_osof),
    .o_eol(a_oeol), .o_eof(a_oeof), .i_ready(a_iready), .o_sof_err(a_sof_err));

  kp_kernel_window #(.LINE_LENGTH(LLB), .LINE_COUNT(LCB), .DATA_WIDTH(DW), .KSIZE(KB)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(b_data), .i_valid(b_valid), .i_sof(b_sof),
    .o_ready(b_oready), .o_window(b_window), .o_valid(b_ovalid), .o_sof(b_osof),
    .o_eol(b_oeol), .o_eof(b_oeof), .i_ready(b_iready), .o_sof_err(b_sof_err));

  int errors = 0;
  int checks = 0;

  px_t  px_q[$];
  win_t win_q[$];
  pos_t exp_q[$];
  int   glob_iter = 0;
  int   first_valid_iter, acc_mark_iter, sof_acc_iter, sof_err_iter, sof_err_cnt, hold_cnt;

  function automatic logic [DW-1:0] pix(input int idx, input int ll);
    return DW'(((idx / ll) << 4) | (idx % ll));
  endfunction

  // Window expected on accept of (x,y): tap(r,c) = pixel(x-k+1+c, y-k+1+r).
  function automatic logic [WB-1:0] exp_win(input int k, input int x, input int y);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        w[(r*k+c)*DW +: DW] = DW'(((y - k + 1 + r) << 4) | (x - k + 1 + c));
    return w;
  endfunction

  task automatic push_ramp(input int first, input int last, input bit sof_first, input int mark_idx);
    for (int i = first; i <= last; i++) begin
      px_t p;
      p.d = pix(i, LL); p.sof = sof_first && (i == first); p.mark = (i == mark_idx);
      px_q.push_back(p);
    end
  endtask

  task automatic add_expected(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      pos_t p;
      p.x = i % LL; p.y = i / LL;
      if (p.x >= K - 1 && p.y >= K - 1) exp_q.push_back(p);
    end
  endtask

  task automatic clear_state();
    win_q.delete(); exp_q.delete();
    first_valid_iter = -1; acc_mark_iter = -1; sof_acc_iter = -1;
    sof_err_iter = -1; sof_err_cnt = 0; hold_cnt = 0;
  endtask

  // Feeds px_q into instance a and records every window handed downstream.
  // Entered and left at posedge+1. Also checks that a stalled window holds.
  task automatic drive_a(input int ready_period, input bit rand_valid, input int drain, input int max_cycles);
    int it = 0, drained = 0;
    bit hold_prev = 0;
    logic [WA+2:0] held = '0;
    forever begin
      if (px_q.size() > 0) begin
        a_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        a_data  = px_q[0].d;
        a_sof   = a_valid & px_q[0].sof;
      end else begin
        a_valid = 1'b0; a_sof = 1'b0;
      end
      a_iready = (ready_period <= 1) ? 1'b1 : ((it % ready_period) == 0);
      #1;
      if (hold_prev) begin
        checks++;
        if (a_ovalid !== 1'b1 || {a_window, a_osof, a_oeol, a_oeof} !== held) begin
          errors++;
          $display("FAIL hold: got valid=%b win=%h expected held %h", a_ovalid, a_window, held);
        end
      end
      if (a_sof_err === 1'b1) begin sof_err_cnt++; sof_err_iter = glob_iter; end
      if (a_ovalid && a_iready) begin
        win_t w;
        w.w = a_window; w.sof = a_osof; w.eol = a_oeol; w.eof = a_oeof;
        win_q.push_back(w);
        if (first_valid_iter < 0) first_valid_iter = glob_iter;
      end
      hold_prev = a_ovalid && !a_iready;
      if (hold_prev) hold_cnt++;
      held = {a_window, a_osof, a_oeol, a_oeof};
      if (a_valid && a_oready) begin
        px_t p;
        p = px_q.pop_front();
        if (p.mark) acc_mark_iter = glob_iter;
        if (p.sof) sof_acc_iter = glob_iter;
      end
      @(posedge clk); #1;
      it++; glob_iter++;
      if (px_q.size() == 0) begin
        if (drained >= drain) break;
        drained++;
      end
      if (it > max_cycles) begin
        checks++; errors++;
        $display("FAIL drive_timeout: got %0d pixels left expected 0", px_q.size());
        px_q.delete();
        break;
      end
    end
    a_valid = 1'b0; a_sof = 1'b0; a_iready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b0; a_sof = 1'b0; a_data = '0; a_iready = 1'b1;
    b_valid = 1'b0; b_sof = 1'b0; b_data = '0; b_iready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", a_ovalid); end
    checks++; if (a_window !== '0) begin errors++; $display("FAIL reset_window: got %h expected 0", a_window); end
    checks++; if (a_oready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", a_oready); end
    checks++; if ({a_osof, a_oeol, a_oeof, a_sof_err} !== 4'b0) begin errors++; $display("FAIL reset_markers: got %b expected 0000", {a_osof, a_oeol, a_oeof, a_sof_err}); end
    checks++; if (b_ovalid !== 1'b0 || b_window !== '0) begin errors++; $display("FAIL reset_b: got valid=%b expected 0 and zero window", b_ovalid); end
    rst = 1'b0;
    #1;
    checks++; if (a_oready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", a_oready); end
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    logic [WB-1:0] ew;
    clear_state();
    push_ramp(0, 47, 1'b0, 2 * LL + 2);
    add_expected(0, 47);
    drive_a(1, 1'b0, 6, 2000);
    checks++; if (win_q.size() != 24) begin errors++; $display("FAIL ramp_count: got %0d expected 24", win_q.size()); end
    for (int i = 0; i < win_q.size() && i < exp_q.size(); i++) begin
      ew = exp_win(K, exp_q[i].x, exp_q[i].y);
      checks++;
      if (win_q[i].w !== ew[WA-1:0] || win_q[i].sof !== (exp_q[i].x == 2 && exp_q[i].y == 2) ||
          win_q[i].eol !== (exp_q[i].x == LL - 1) || win_q[i].eof !== (exp_q[i].x == LL - 1 && exp_q[i].y == LC - 1)) begin
        errors++; $display("FAIL ramp_win%0d: got %h sof%b eol%b eof%b expected %h", i, win_q[i].w, win_q[i].sof, win_q[i].eol, win_q[i].eof, ew[WA-1:0]);
      end
    end
    if (win_q.size() > 0) begin
      checks++;
      if (win_q[0].sof !== 1'b1 || win_q[0].w[4*DW +: DW] !== 16'h0011 || win_q[0].w[0 +: DW] !== 16'h0000 || win_q[0].w[8*DW +: DW] !== 16'h0022) begin
        errors++; $display("FAIL ramp_first: got %h expected centre 0011 tap00 0000 tap22 0022 sof", win_q[0].w);
      end
      checks++;
      if (win_q[$].eof !== 1'b1 || win_q[$].eol !== 1'b1 || win_q[$].w[4*DW +: DW] !== 16'h0046) begin
        errors++; $display("FAIL ramp_last: got centre %h eof%b eol%b expected 0046 eof1 eol1", win_q[$].w[4*DW +: DW], win_q[$].eof, win_q[$].eol);
      end
    end
    checks++; if (first_valid_iter != acc_mark_iter + 1) begin errors++; $display("FAIL ramp_latency: got iter %0d expected %0d", first_valid_iter, acc_mark_iter + 1); end
    checks++; if (sof_err_cnt != 0) begin errors++; $display("FAIL ramp_sof_err: got %0d expected 0", sof_err_cnt); end
  endtask

  task automatic test_backpressure();
    logic [WB-1:0] ew;
    clear_state();
    push_ramp(0, 47, 1'b0, -1);
    add_expected(0, 47);
    drive_a(3, 1'b1, 6, 3000);
    checks++; if (win_q.size() != 24) begin errors++; $display("FAIL bp_count: got %0d expected 24", win_q.size()); end
    for (int i = 0; i < win_q.size() && i < exp_q.size(); i++) begin
      ew = exp_win(K, exp_q[i].x, exp_q[i].y);
      checks++;
      if (win_q[i].w !== ew[WA-1:0] || win_q[i].eol !== (exp_q[i].x == LL - 1)) begin
        errors++; $display("FAIL bp_win%0d: got %h eol%b expected %h", i, win_q[i].w, win_q[i].eol, ew[WA-1:0]);
      end
    end
    checks++; if (hold_cnt == 0) begin errors++; $display("FAIL bp_stalls: got %0d stall cycles expected >0", hold_cnt); end
  endtask

  task automatic test_k5();
    logic [WB-1:0] wq[$];
    logic          eolq[$], sofq[$];
    logic [WB-1:0] ew;
    int idx = 0;
    for (int it = 0; it < 160; it++) begin
      b_valid = (idx < LLB * LCB);
      b_data  = pix(idx, LLB);
      b_iready = 1'b1;
      #1;
      if (b_ovalid) begin wq.push_back(b_window); eolq.push_back(b_oeol); sofq.push_back(b_osof); end
      if (b_valid && b_oready) idx++;
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    checks++; if (idx != LLB * LCB) begin errors++; $display("FAIL k5_accepts: got %0d expected %0d", idx, LLB * LCB); end
    checks++; if (wq.size() != 48) begin errors++; $display("FAIL k5_count: got %0d expected 48", wq.size()); end
    for (int i = 0; i < wq.size() && i < 48; i++) begin
      ew = exp_win(KB, 4 + i % 12, 4 + i / 12);
      checks++;
      if (wq[i] !== ew || eolq[i] !== (i % 12 == 11) || sofq[i] !== (i == 0)) begin
        errors++; $display("FAIL k5_win%0d: got eol%b sof%b win %h expected %h", i, eolq[i], sofq[i], wq[i][255:0], ew[255:0]);
      end
    end
    if (wq.size() > 0) begin
      checks++;
      if (wq[0][12*DW +: DW] !== 16'h0022 || wq[0][0 +: DW] !== 16'h0000) begin
        errors++; $display("FAIL k5_first: got centre %h tap00 %h expected 0022 0000", wq[0][12*DW +: DW], wq[0][0 +: DW]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WB-1:0] ew;
    int sof_seen = 0;
    clear_state();
    push_ramp(0, 47, 1'b1, -1);
    push_ramp(0, 47, 1'b1, -1);
    add_expected(0, 47);
    add_expected(0, 47);
    drive_a(1, 1'b0, 6, 2000);
    checks++; if (win_q.size() != 48) begin errors++; $display("FAIL b2b_count: got %0d expected 48", win_q.size()); end
    for (int i = 0; i < win_q.size() && i < exp_q.size(); i++) begin
      ew = exp_win(K, exp_q[i].x, exp_q[i].y);
      if (win_q[i].sof) sof_seen++;
      checks++;
      if (win_q[i].w !== ew[WA-1:0] || win_q[i].eof !== (exp_q[i].x == LL - 1 && exp_q[i].y == LC - 1)) begin
        errors++; $display("FAIL b2b_win%0d: got %h eof%b expected %h", i, win_q[i].w, win_q[i].eof, ew[WA-1:0]);
      end
    end
    checks++; if (sof_seen != 2) begin errors++; $display("FAIL b2b_sof: got %0d expected 2", sof_seen); end
    checks++; if (sof_err_cnt != 0) begin errors++; $display("FAIL b2b_sof_err: got %0d expected 0", sof_err_cnt); end
  endtask

  task automatic test_sof_resync();
    logic [WB-1:0] ew;
    clear_state();
    push_ramp(0, 3 * LL + 4, 1'b0, -1);
    push_ramp(0, 47, 1'b1, -1);
    add_expected(0, 3 * LL + 4);
    add_expected(0, 47);
    drive_a(1, 1'b0, 6, 2000);
    checks++; if (win_q.size() != 33) begin errors++; $display("FAIL resync_count: got %0d expected 33", win_q.size()); end
    for (int i = 0; i < win_q.size() && i < exp_q.size(); i++) begin
      ew = exp_win(K, exp_q[i].x, exp_q[i].y);
      checks++;
      if (win_q[i].w !== ew[WA-1:0] || win_q[i].sof !== (exp_q[i].x == 2 && exp_q[i].y == 2)) begin
        errors++; $display("FAIL resync_win%0d: got %h sof%b expected %h", i, win_q[i].w, win_q[i].sof, ew[WA-1:0]);
      end
    end
    checks++; if (sof_err_cnt != 1) begin errors++; $display("FAIL resync_err_count: got %0d expected 1", sof_err_cnt); end
    checks++; if (sof_err_iter != sof_acc_iter + 1) begin errors++; $display("FAIL resync_err_time: got %0d expected %0d", sof_err_iter, sof_acc_iter + 1); end
  endtask

  task automatic test_reset_mid_frame();
    logic [WB-1:0] ew;
    clear_state();
    push_ramp(0, 4 * LL + 4, 1'b0, -1);
    drive_a(1, 1'b0, 0, 2000);
    a_valid = 1'b1; a_data = 16'hbeef; rst = 1'b1;
    #1;
    checks++; if (a_oready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0", a_oready); end
    @(posedge clk); #1;
    checks++; if (a_ovalid !== 1'b0 || a_window !== '0) begin errors++; $display("FAIL mid_rst_out: got valid=%b win=%h expected 0", a_ovalid, a_window); end
    checks++; if ({a_osof, a_oeol, a_oeof, a_sof_err} !== 4'b0) begin errors++; $display("FAIL mid_rst_markers: got %b expected 0000", {a_osof, a_oeol, a_oeof, a_sof_err}); end
    rst = 1'b0; a_valid = 1'b0;
    clear_state();
    push_ramp(0, 47, 1'b0, -1);
    add_expected(0, 47);
    drive_a(1, 1'b0, 6, 2000);
    checks++; if (win_q.size() != 24) begin errors++; $display("FAIL mid_rst_count: got %0d expected 24", win_q.size()); end
    for (int i = 0; i < win_q.size() && i < exp_q.size(); i++) begin
      ew = exp_win(K, exp_q[i].x, exp_q[i].y);
      checks++;
      if (win_q[i].w !== ew[WA-1:0] || win_q[i].sof !== (i == 0)) begin
        errors++; $display("FAIL mid_rst_win%0d: got %h sof%b expected %h", i, win_q[i].w, win_q[i].sof, ew[WA-1:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_k5();
    test_back_to_back();
    test_sof_resync();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
